// File: rtl/pwm_pkg.sv
// Shared defaults and the modular phase-subtract helper for the PWM generator.
package pwm_pkg;
  localparam int PWM_NUM_CH = 4;
  localparam int PWM_CNT_W  = 32;
  localparam int PWM_MAX_W  = 32;

  typedef logic [PWM_MAX_W:0] pwm_wide_t;

  // Position of cnt within a period that starts at ph; one extra bit keeps cnt+p from overflowing.
  function automatic pwm_wide_t pwm_shift(pwm_wide_t cnt, pwm_wide_t ph, pwm_wide_t p);
    return (cnt >= ph) ? (cnt - ph) : (cnt + p - ph);
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty/phase/polarity registers, compare against the shared counter, output flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_duty,
  input  logic [CNT_W-1:0] load_phase,
  input  logic             load_pol,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] period,
  input  logic             run,
  input  logic             valid,
  output logic             pwm_out
);
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             pol_q, pol_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] ph;
  pwm_wide_t        pos;
  logic             act;

  always_comb begin
    duty_d  = duty_q;
    phase_d = phase_q;
    pol_d   = pol_q;
    if (load_en) begin
      duty_d  = load_duty;
      phase_d = load_phase;
      pol_d   = load_pol;
    end
    // Out-of-range phase collapses to zero rather than wrapping.
    ph    = (phase_q >= period) ? '0 : phase_q;
    pos   = pwm_shift(pwm_wide_t'(cnt), pwm_wide_t'(ph), pwm_wide_t'(period));
    act   = run && (pos < pwm_wide_t'(duty_q));
    // Until a configuration has ever been applied the pin is held low regardless of polarity.
    out_d = valid ? (act ^ ~pol_q) : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q  <= '0;
      phase_q <= '0;
      pol_q   <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      phase_q <= phase_d;
      pol_q   <= pol_d;
      out_q   <= out_d;
    end
  end

  assign pwm_out = out_q;
endmodule

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM: shared period counter, double-buffered configuration applied at period wrap.
module pwm_multichannel_gen
  import pwm_pkg::*;
#(
  parameter int NUM_CH = PWM_NUM_CH,
  parameter int CNT_W  = PWM_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic [NUM_CH-1:0]       cfg_pol,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic                    cfg_pending
);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        period_q, period_d;
  logic [CNT_W-1:0]        sh_period_q, sh_period_d;
  logic [NUM_CH*CNT_W-1:0] sh_duty_q, sh_duty_d;
  logic [NUM_CH*CNT_W-1:0] sh_phase_q, sh_phase_d;
  logic [NUM_CH-1:0]       sh_pol_q, sh_pol_d;
  logic                    pending_q, pending_d;
  logic                    valid_q, valid_d;
  logic                    tick_q, tick_d;
  logic                    wrap, direct_load, apply, upd, run;
  logic [NUM_CH-1:0]       ch_out;

  always_comb begin
    run         = enable && (period_q != '0);
    wrap        = run && (cnt_q == period_q - CNT_W'(1));
    direct_load = cfg_load && !enable;
    // A stopped or zero-period counter has no boundary to wait for, so pending config applies at once.
    apply       = pending_q && !direct_load && (!run || wrap);
    upd         = direct_load || apply;

    cnt_d       = (!run || wrap) ? '0 : cnt_q + CNT_W'(1);
    tick_d      = wrap;
    period_d    = period_q;
    if (direct_load)  period_d = cfg_period;
    else if (apply)   period_d = sh_period_q;
    valid_d     = valid_q || upd;

    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    sh_phase_d  = sh_phase_q;
    sh_pol_d    = sh_pol_q;
    if (cfg_load) begin
      sh_period_d = cfg_period;
      sh_duty_d   = cfg_duty;
      sh_phase_d  = cfg_phase;
      sh_pol_d    = cfg_pol;
    end

    pending_d = pending_q;
    if (cfg_load && enable) pending_d = 1'b1;
    else if (upd)           pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      period_q    <= '0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      sh_phase_q  <= '0;
      sh_pol_q    <= '0;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      sh_phase_q  <= sh_phase_d;
      sh_pol_q    <= sh_pol_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      tick_q      <= tick_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      pwm_channel #(.CNT_W(CNT_W)) u_ch (
        .clk        (clk),
        .rst        (rst),
        .load_en    (upd),
        .load_duty  (direct_load ? cfg_duty[gi*CNT_W +: CNT_W]  : sh_duty_q[gi*CNT_W +: CNT_W]),
        .load_phase (direct_load ? cfg_phase[gi*CNT_W +: CNT_W] : sh_phase_q[gi*CNT_W +: CNT_W]),
        .load_pol   (direct_load ? cfg_pol[gi] : sh_pol_q[gi]),
        .cnt        (cnt_q),
        .period     (period_q),
        .run        (run),
        .valid      (valid_q),
        .pwm_out    (ch_out[gi])
      );
    end
  endgenerate

  assign pwm_out     = ch_out;
  assign period_tick = tick_q;
  assign cfg_pending = pending_q;
endmodule

// File: tb/tb_pwm_multichannel_gen.sv
// Directed plus randomized bench for pwm_multichannel_gen, checked against a period-arithmetic model.
module tb_pwm_multichannel_gen;
  localparam int NCH = 4;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [W-1:0]     cfg_period = '0;
  logic [NCH*W-1:0] cfg_duty = '0;
  logic [NCH*W-1:0] cfg_phase = '0;
  logic [NCH-1:0]   cfg_pol = '0;
  logic             cfg_load = 1'b0;
  logic [NCH-1:0]   pwm_out;
  logic             period_tick;
  logic             cfg_pending;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: what is in force, what is staged, where we are in the period.
  longint m_p, m_cnt, s_p;
  longint m_duty[NCH], m_phase[NCH], s_duty[NCH], s_phase[NCH];
  bit     m_pol[NCH], s_pol[NCH];
  bit     m_pend, m_valid;
  logic [NCH-1:0] e_out;
  logic           e_tick;

  pwm_multichannel_gen #(.NUM_CH(NCH), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg_period(cfg_period),
    .cfg_duty(cfg_duty), .cfg_phase(cfg_phase), .cfg_pol(cfg_pol),
    .cfg_load(cfg_load), .pwm_out(pwm_out), .period_tick(period_tick),
    .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_cnt = 0; s_p = 0; m_pend = 0; m_valid = 0;
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = 0; m_phase[i] = 0; m_pol[i] = 0;
      s_duty[i] = 0; s_phase[i] = 0; s_pol[i] = 0;
    end
    e_out = '0; e_tick = 1'b0;
  endtask

  // Is channel i inside its active window at offset m_cnt of the current period?
  function automatic bit ch_active(int i);
    longint ph, pos;
    ph  = (m_phase[i] >= m_p) ? 0 : m_phase[i];
    pos = (m_cnt - ph + m_p) % m_p;
    return pos < m_duty[i];
  endfunction

  task automatic model_step();
    bit running, last;
    running = enable && (m_p != 0);
    last    = running && (m_cnt == m_p - 1);
    for (int i = 0; i < NCH; i++)
      e_out[i] = !m_valid ? 1'b0 : ((running && ch_active(i)) ? m_pol[i] : !m_pol[i]);
    e_tick = last;
    m_cnt  = (running && !last) ? m_cnt + 1 : 0;
    if (cfg_load && !enable) begin
      m_p = cfg_period; m_pend = 0; m_valid = 1;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = cfg_duty[i*W +: W]; m_phase[i] = cfg_phase[i*W +: W]; m_pol[i] = cfg_pol[i];
      end
    end else if (m_pend && (!running || last)) begin
      m_p = s_p; m_pend = 0; m_valid = 1;
      for (int i = 0; i < NCH; i++) begin
        m_duty[i] = s_duty[i]; m_phase[i] = s_phase[i]; m_pol[i] = s_pol[i];
      end
    end
    if (cfg_load) begin
      s_p = cfg_period;
      for (int i = 0; i < NCH; i++) begin
        s_duty[i] = cfg_duty[i*W +: W]; s_phase[i] = cfg_phase[i*W +: W]; s_pol[i] = cfg_pol[i];
      end
      if (enable) m_pend = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(e_out));
    chk("period_tick", 32'(period_tick), 32'(e_tick));
    chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    cfg_load = 1'b0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic set_ch(int ch, int duty, int phase, bit pol);
    cfg_duty[ch*W +: W]  = W'(duty);
    cfg_phase[ch*W +: W] = W'(phase);
    cfg_pol[ch]          = pol;
  endtask

  task automatic wait_cnt(longint target);
    int guard = 0;
    while (m_cnt != target && guard < 100) begin cycle(); guard++; end
    chk("wait_cnt_bound", 32'(guard < 100), 32'd1);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_pwm_out", 32'(pwm_out), 32'd0);
    chk("reset_tick", 32'(period_tick), 32'd0);
    chk("reset_pending", 32'(cfg_pending), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    run(3);

    // 1: load while disabled, then run: ch0 high 3 of every 10 cycles
    cfg_period = 10; set_ch(0, 3, 0, 1'b1);
    for (int i = 1; i < NCH; i++) set_ch(i, 0, 0, 1'b1);
    cfg_load = 1'b1; cycle();
    enable = 1'b1; run(25);

    // 2: phase offsets, including one past the period
    enable = 1'b0; cycle();
    set_ch(0, 3, 0, 1'b1); set_ch(1, 3, 4, 1'b1); set_ch(2, 3, 12, 1'b1); set_ch(3, 3, 9, 1'b1);
    cfg_load = 1'b1; cycle();
    enable = 1'b1; run(22);

    // 3: mid-period load, then a load landing in the wrap cycle
    wait_cnt(5);
    set_ch(0, 7, 0, 1'b1); cfg_load = 1'b1; cycle();
    chk("pending_after_load", 32'(cfg_pending), 32'd1);
    run(25);
    wait_cnt(9);
    set_ch(0, 5, 0, 1'b1); cfg_load = 1'b1; cycle();
    chk("pending_wrap_load", 32'(cfg_pending), 32'd1);
    run(25);

    // 4: duty extremes under both polarities, loaded through the pending path
    set_ch(0, 0, 0, 1'b1); set_ch(1, 10, 3, 1'b1); set_ch(2, 15, 0, 1'b0); set_ch(3, 0, 2, 1'b0);
    cfg_load = 1'b1; run(25);
    set_ch(0, 0, 0, 1'b0); set_ch(1, 10, 3, 1'b0); set_ch(2, 15, 0, 1'b1); set_ch(3, 10, 2, 1'b1);
    cfg_load = 1'b1; run(25);

    // 5: single-cycle period, zero period, and leaving zero period
    cfg_period = 1;
    for (int i = 0; i < NCH; i++) set_ch(i, 1, 0, 1'b1);
    cfg_load = 1'b1; run(15);
    cfg_period = 0; cfg_load = 1'b1; run(6);
    cfg_period = 6; set_ch(0, 2, 1, 1'b1); cfg_load = 1'b1; run(14);
    enable = 1'b0; run(3); enable = 1'b1; run(8);

    // Random configurations, load timing and enable state
    for (int r = 0; r < 30; r++) begin
      cfg_period = ($urandom_range(0, 9) == 0) ? 32'd0 : W'($urandom_range(1, 12));
      for (int i = 0; i < NCH; i++)
        set_ch(i, $urandom_range(0, 14), $urandom_range(0, 14), 1'($urandom_range(0, 1)));
      enable = ($urandom_range(0, 4) != 0);
      cfg_load = 1'b1; cycle();
      enable = 1'b1;
      run($urandom_range(5, 30));
    end

    // 6: async reset with a pending load, outputs hold 0 until reconfigured
    enable = 1'b0; cfg_period = 10;
    for (int i = 0; i < NCH; i++) set_ch(i, 4, i, 1'b1);
    cfg_load = 1'b1; cycle();
    enable = 1'b1; run(4);
    set_ch(0, 8, 0, 1'b1); cfg_load = 1'b1; cycle();
    chk("pending_before_rst", 32'(cfg_pending), 32'd1);
    rst = 1'b1; #1;
    chk("rst_pwm_out", 32'(pwm_out), 32'd0);
    chk("rst_tick", 32'(period_tick), 32'd0);
    chk("rst_pending", 32'(cfg_pending), 32'd0);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    run(12);
    for (int i = 0; i < NCH; i++) set_ch(i, 2, 0, 1'b0);
    cfg_load = 1'b1; run(12);
    enable = 1'b0; cfg_load = 1'b1; cycle();
    enable = 1'b1; run(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
